// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between two write-back
//   requesters: A (ALU result) and B (memory load). Each requester has a
//   small FIFO. A two-state round-robin arbiter drains the FIFOs into a
//   registered write stage. busy_mask flags every register that has a write
//   still queued, so issue logic can stall on pending writes.
//
//   Optional feature macro: WB_FORWARD_EN
//     When defined, readRegister1/2 and fwd_valid1/2, fwd_data1/2 exist and
//     bypass the value being written this cycle. This covers the register
//     file returning stale data in the cycle it is written.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   req_a_valid/ready/reg/data  requester A handshake + destination + data
//   req_b_valid/ready/reg/data  requester B handshake + destination + data
//   regWrite/writeRegister/writeData  registered register-file write port
//   busy_mask                   bit r set while a write to r is queued
//   readRegister1/2, fwd_*      read-port bypass (WB_FORWARD_EN only)
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_a_valid,
   output logic              req_a_ready,
   input  logic [ADDR_W-1:0] req_a_reg,
   input  logic [DATA_W-1:0] req_a_data,
   input  logic              req_b_valid,
   output logic              req_b_ready,
   input  logic [ADDR_W-1:0] req_b_reg,
   input  logic [DATA_W-1:0] req_b_data,
   output logic              regWrite,
   output logic [ADDR_W-1:0] writeRegister,
   output logic [DATA_W-1:0] writeData,
`ifdef WB_FORWARD_EN
   input  logic [ADDR_W-1:0] readRegister1,
   input  logic [ADDR_W-1:0] readRegister2,
   output logic              fwd_valid1,
   output logic              fwd_valid2,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2,
`endif
   output logic [31:0]       busy_mask
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {PRI_A, PRI_B} pri_t;

   pri_t pri, pri_nxt;

   logic [ADDR_W-1:0] a_reg_mem  [DEPTH];
   logic [DATA_W-1:0] a_data_mem [DEPTH];
   logic [ADDR_W-1:0] b_reg_mem  [DEPTH];
   logic [DATA_W-1:0] b_data_mem [DEPTH];

   logic [PW-1:0] a_wr, a_rd, b_wr, b_rd;
   logic [PW-1:0] a_cnt, b_cnt;
   logic          a_full, a_empty, b_full, b_empty;
   logic          a_push, b_push;
   logic          gnt_a, gnt_b;
   logic [ADDR_W-1:0] head_reg;
   logic [DATA_W-1:0] head_data;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign a_full  = ((a_wr ^ a_rd) == PW'(DEPTH));
   assign b_full  = ((b_wr ^ b_rd) == PW'(DEPTH));
   assign a_empty = (a_wr == a_rd);
   assign b_empty = (b_wr == b_rd);
   assign a_cnt   = a_wr - a_rd;
   assign b_cnt   = b_wr - b_rd;

   assign req_a_ready = !a_full;
   assign req_b_ready = !b_full;

   // Writes to r0 complete the handshake but are dropped here.
   assign a_push = req_a_valid && !a_full && (req_a_reg != '0);
   assign b_push = req_b_valid && !b_full && (req_b_reg != '0);

   // FIFO storage: contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (a_push) begin
         a_reg_mem[a_wr[AW-1:0]]  <= req_a_reg;
         a_data_mem[a_wr[AW-1:0]] <= req_a_data;
      end
      if (b_push) begin
         b_reg_mem[b_wr[AW-1:0]]  <= req_b_reg;
         b_data_mem[b_wr[AW-1:0]] <= req_b_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_wr <= '0;
         a_rd <= '0;
         b_wr <= '0;
         b_rd <= '0;
      end else begin
         if (a_push) a_wr <= a_wr + PW'(1);
         if (gnt_a)  a_rd <= a_rd + PW'(1);
         if (b_push) b_wr <= b_wr + PW'(1);
         if (gnt_b)  b_rd <= b_rd + PW'(1);
      end
   end

   // Round-robin arbiter state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pri <= PRI_A;
      else       pri <= pri_nxt;
   end

   always_comb begin
      gnt_a   = 1'b0;
      gnt_b   = 1'b0;
      pri_nxt = pri;
      if (!a_empty && (b_empty || pri == PRI_A)) begin
         gnt_a   = 1'b1;
         pri_nxt = PRI_B;
      end else if (!b_empty) begin
         gnt_b   = 1'b1;
         pri_nxt = PRI_A;
      end
   end

   assign head_reg  = gnt_a ? a_reg_mem[a_rd[AW-1:0]]  : b_reg_mem[b_rd[AW-1:0]];
   assign head_data = gnt_a ? a_data_mem[a_rd[AW-1:0]] : b_data_mem[b_rd[AW-1:0]];

   // Write stage: index/data hold between grants.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regWrite      <= 1'b0;
         writeRegister <= '0;
         writeData     <= '0;
      end else begin
         regWrite <= gnt_a || gnt_b;
         if (gnt_a || gnt_b) begin
            writeRegister <= head_reg;
            writeData     <= head_data;
         end
      end
   end

   // Walk the occupied slots of each FIFO, starting at its read pointer.
   always_comb begin
      busy_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (PW'(k) < a_cnt) busy_mask[a_reg_mem[AW'(a_rd + PW'(k))]] = 1'b1;
         if (PW'(k) < b_cnt) busy_mask[b_reg_mem[AW'(b_rd + PW'(k))]] = 1'b1;
      end
   end

`ifdef WB_FORWARD_EN
   assign fwd_valid1 = regWrite && (writeRegister == readRegister1) && (readRegister1 != '0);
   assign fwd_valid2 = regWrite && (writeRegister == readRegister2) && (readRegister2 != '0);
   assign fwd_data1  = fwd_valid1 ? writeData : '0;
   assign fwd_data2  = fwd_valid2 ? writeData : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vectors, a queue-based model
// of the two requester FIFOs and the alternating arbiter, one per-cycle
// compare process, and literal expectations for each scenario.
module tb_regfile_wb_arbiter;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_a_valid = 1'b0, req_b_valid = 1'b0;
   logic          req_a_ready, req_b_ready;
   logic [AW-1:0] req_a_reg = '0, req_b_reg = '0;
   logic [DW-1:0] req_a_data = '0, req_b_data = '0;
   logic          regWrite;
   logic [AW-1:0] writeRegister;
   logic [DW-1:0] writeData;
   logic [31:0]   busy_mask;
`ifdef WB_FORWARD_EN
   logic [AW-1:0] readRegister1 = '0, readRegister2 = '0;
   logic          fwd_valid1, fwd_valid2;
   logic [DW-1:0] fwd_data1, fwd_data2;
`endif

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .req_a_valid(req_a_valid), .req_a_ready(req_a_ready),
      .req_a_reg(req_a_reg), .req_a_data(req_a_data),
      .req_b_valid(req_b_valid), .req_b_ready(req_b_ready),
      .req_b_reg(req_b_reg), .req_b_data(req_b_data),
      .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
`ifdef WB_FORWARD_EN
      .readRegister1(readRegister1), .readRegister2(readRegister2),
      .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
      .busy_mask(busy_mask)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [AW-1:0] r;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          qa[$];
   ent_t          qb[$];
   bit            m_pri_b = 1'b0;   // 1: B is favoured when both queues hold entries
   logic          m_we    = 1'b0;
   logic [AW-1:0] m_wreg  = '0;
   logic [DW-1:0] m_wdata = '0;

   task automatic model_reset();
      qa.delete();
      qb.delete();
      m_pri_b = 1'b0;
      m_we    = 1'b0;
      m_wreg  = '0;
      m_wdata = '0;
   endtask

   // One clock edge: at most one write leaves, and each source enqueues if
   // its queue had room before the edge.
   task automatic model_edge();
      int sa, sb;
      bit ga, gb;
      sa = qa.size();
      sb = qb.size();
      ga = (sa > 0) && (sb == 0 || !m_pri_b);
      gb = !ga && (sb > 0);
      m_we = ga || gb;
      if (ga) begin
         m_wreg = qa[0].r; m_wdata = qa[0].d; void'(qa.pop_front()); m_pri_b = 1'b1;
      end else if (gb) begin
         m_wreg = qb[0].r; m_wdata = qb[0].d; void'(qb.pop_front()); m_pri_b = 1'b0;
      end
      if (req_a_valid && sa < DEPTH && req_a_reg != 0) qa.push_back('{req_a_reg, req_a_data});
      if (req_b_valid && sb < DEPTH && req_b_reg != 0) qb.push_back('{req_b_reg, req_b_data});
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] b;
      b = '0;
      foreach (qa[i]) b[qa[i].r] = 1'b1;
      foreach (qb[i]) b[qb[i].r] = 1'b1;
      return b;
   endfunction

   // Advance one clock; model and stimulus share this process, so inputs are
   // stable at the edge and change 1 time unit later.
   task automatic step();
      @(posedge clk);
      if (!reset) model_edge();
      cyc++;
      #1;
   endtask

   // ---------------- write log ----------------
   int wlog_r[$];
   int wlog_d[$];
   int wlog_c[$];

   task automatic clear_log();
      wlog_r.delete(); wlog_d.delete(); wlog_c.delete();
   endtask

   initial forever begin
      @(negedge clk);
      if (!reset && regWrite === 1'b1) begin
         wlog_r.push_back(int'(writeRegister));
         wlog_d.push_back(int'(writeData));
         wlog_c.push_back(cyc);
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         check("cmp_regWrite", regWrite, m_we);
         check("cmp_writeRegister", writeRegister, m_wreg);
         check("cmp_writeData", writeData, m_wdata);
         check("cmp_busy_mask", busy_mask, model_busy());
         check("cmp_ready_a", req_a_ready, qa.size() < DEPTH);
         check("cmp_ready_b", req_b_ready, qb.size() < DEPTH);
`ifdef WB_FORWARD_EN
         check("cmp_fwd_valid1", fwd_valid1, m_we && m_wreg == readRegister1 && readRegister1 != 0);
         check("cmp_fwd_valid2", fwd_valid2, m_we && m_wreg == readRegister2 && readRegister2 != 0);
         check("cmp_fwd_data1", fwd_data1,
               (m_we && m_wreg == readRegister1 && readRegister1 != 0) ? m_wdata : '0);
         check("cmp_fwd_data2", fwd_data2,
               (m_we && m_wreg == readRegister2 && readRegister2 != 0) ? m_wdata : '0);
`endif
      end
   end

   task automatic idle_inputs();
      req_a_valid = 1'b0; req_a_reg = '0; req_a_data = '0;
      req_b_valid = 1'b0; req_b_reg = '0; req_b_data = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      idle_inputs();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic drive_a(input logic v, input int r, input int d);
      req_a_valid = v; req_a_reg = AW'(r); req_a_data = DW'(d);
   endtask

   task automatic drive_b(input logic v, input int r, input int d);
      req_b_valid = v; req_b_reg = AW'(r); req_b_data = DW'(d);
   endtask

   initial begin
      int ia, ib, iter;
      logic ra, rb;
      int exp_r[8];
      int exp_d[8];
      int exp4[6];

      // ---- 1: reset while A holds two queued entries ----
      do_reset();
      drive_a(1, 3, 'h33); drive_b(1, 9, 'h99); step();   // edge1
      drive_a(1, 4, 'h44); drive_b(0, 0, 0);     step();   // edge2: grant A (r3)
      drive_a(1, 6, 'h66);                      step();   // edge3: grant B (r9)
      idle_inputs();
      check("t1_busy_before_reset", busy_mask, 32'h0000_0050);
      check("t1_write_before_reset", writeRegister, 9);
      reset = 1'b1;
      model_reset();
      #1;
      check("t1_regWrite_in_reset", regWrite, 0);
      check("t1_busy_in_reset", busy_mask, 0);
      check("t1_readies_in_reset", {req_a_ready, req_b_ready}, 2'b11);
      check("t1_wreg_in_reset", writeRegister, 0);
      check("t1_wdata_in_reset", writeData, 0);
      step();
      reset = 1'b0;
      clear_log();
      repeat (4) step();
      check("t1_no_write_after_reset", wlog_r.size(), 0);

      // ---- 2: single write r5 = 0x11, latency and busy window ----
      do_reset();
      clear_log();
      drive_a(1, 5, 'h11); step();                          // edge1: accept
      idle_inputs();
      check("t2_busy_after_accept", busy_mask, 32'h0000_0020);
      check("t2_no_write_yet", regWrite, 0);
      step();                                               // edge2: write
      check("t2_regWrite", regWrite, 1);
      check("t2_writeRegister", writeRegister, 5);
      check("t2_writeData", writeData, 'h11);
      check("t2_busy_cleared", busy_mask, 0);
      step();
      check("t2_regWrite_drops", regWrite, 0);
      check("t2_wreg_holds", writeRegister, 5);

      // ---- 3: both sources streaming, alternating grants ----
      do_reset();
      clear_log();
      ia = 0; ib = 0; iter = 0;
      while ((ia < 4 || ib < 4) && iter < 40) begin
         drive_a(ia < 4, 1 + ia, 'hA0 + ia);
         drive_b(ib < 4, 8 + ib, 'hB0 + ib);
         ra = req_a_ready;
         rb = req_b_ready;
         step();
         if (ia < 4 && ra) ia++;
         if (ib < 4 && rb) ib++;
         iter++;
      end
      idle_inputs();
      check("t3_all_accepted", {ia[7:0], ib[7:0]}, {8'd4, 8'd4});
      repeat (4) step();
      exp_r = '{1, 8, 2, 9, 3, 10, 4, 11};
      exp_d = '{'hA0, 'hB0, 'hA1, 'hB1, 'hA2, 'hB2, 'hA3, 'hB3};
      check("t3_write_count", wlog_r.size(), 8);
      if (wlog_r.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_order_reg%0d", i), wlog_r[i], exp_r[i]);
            check($sformatf("t3_order_data%0d", i), wlog_d[i], exp_d[i]);
         end
         check("t3_one_per_cycle", wlog_c[7] - wlog_c[0], 7);
      end

      // ---- 4: B fills to DEPTH, third entry waits for a pop ----
      do_reset();
      clear_log();
      drive_a(1, 1, 'hA1); drive_b(1, 17, 'hB1); step();   // edge1
      drive_a(1, 2, 'hA2); drive_b(1, 18, 'hB2); step();   // edge2
      check("t4_b_full_ready", req_b_ready, 0);
      drive_a(1, 3, 'hA3); drive_b(1, 20, 'hB3); step();   // edge3: B rejected, B popped
      check("t4_b_ready_after_pop", req_b_ready, 1);
      check("t4_third_not_taken", busy_mask[20], 0);
      drive_a(0, 0, 0);                           step();   // edge4: B accepted
      check("t4_third_taken", busy_mask[20], 1);
      idle_inputs();
      repeat (5) step();
      exp4 = '{1, 17, 2, 18, 3, 20};
      check("t4_write_count", wlog_r.size(), 6);
      if (wlog_r.size() == 6)
         for (int i = 0; i < 6; i++) check($sformatf("t4_order%0d", i), wlog_r[i], exp4[i]);

      // ---- 5: write to r0 is swallowed ----
      do_reset();
      clear_log();
      drive_a(1, 0, 'hFF);
      check("t5_ready_r0", req_a_ready, 1);
      step();
      idle_inputs();
      check("t5_busy_r0", busy_mask, 0);
      repeat (3) step();
      check("t5_no_write_r0", wlog_r.size(), 0);

`ifdef WB_FORWARD_EN
      // ---- 6: bypass of the value being written ----
      do_reset();
      readRegister1 = 7;
      readRegister2 = 0;
      drive_a(1, 7, 'hABCD); step();
      idle_inputs();
      step();
      check("t6_fwd_valid1", fwd_valid1, 1);
      check("t6_fwd_data1", fwd_data1, 'hABCD);
      check("t6_fwd_valid2", fwd_valid2, 0);
      check("t6_fwd_data2", fwd_data2, 0);
      step();
      check("t6_fwd_valid1_off", fwd_valid1, 0);
      check("t6_fwd_data1_off", fwd_data1, 0);
`endif

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (regWrite / writeRegister / writeData) between two write-back requesters: A (ALU result) and B (memory load). Each requester has a small FIFO, and a round-robin arbiter drains the FIFOs into a registered write stage. The block also exports a scoreboard mask so issue logic can stall on registers with pending writes. It sits between the execute/memory stages and the 32x32 register file.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width (32 registers)
DEPTH, 2, entries per requester FIFO; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
req_a_valid  in  1  requester A has a write
req_a_ready  out  1  A FIFO not full
req_a_reg  in  ADDR_W  A destination register
req_a_data  in  DATA_W  A write data
req_b_valid  in  1  requester B has a write
req_b_ready  out  1  B FIFO not full
req_b_reg  in  ADDR_W  B destination register
req_b_data  in  DATA_W  B write data
regWrite  out  1  register-file write enable (registered)
writeRegister  out  ADDR_W  register-file write index (registered)
writeData  out  DATA_W  register-file write data (registered)
busy_mask  out  32  bit r = 1 if a write to r is queued in either FIFO
readRegister1  in  ADDR_W  [WB_FORWARD_EN only] read port 1 index
readRegister2  in  ADDR_W  [WB_FORWARD_EN only] read port 2 index
fwd_valid1  out  1  [WB_FORWARD_EN only] port 1 bypass hit
fwd_valid2  out  1  [WB_FORWARD_EN only] port 2 bypass hit
fwd_data1  out  DATA_W  [WB_FORWARD_EN only] port 1 bypass data
fwd_data2  out  DATA_W  [WB_FORWARD_EN only] port 2 bypass data

Behaviour:
- Reset (async): FIFOs empty; regWrite=0, writeRegister=0, writeData=0, busy_mask=0; round-robin priority = A. Queued writes are discarded; reset mid-drain produces no further regWrite pulses.
- Handshake: a transfer occurs on a rising edge with valid && ready. ready = !full only. A full FIFO that pops in the same cycle does not accept (no pass-through).
- Register 0: requests with reg==0 are accepted (they consume the handshake) and are never enqueued. They never reach regWrite and never set busy_mask.
- Order: FIFO order is preserved within one requester. Order across requesters follows arbitration only; issue logic uses busy_mask to avoid cross-source WAW hazards.
- Arbiter has two states, PRI_A and PRI_B.
  - Each cycle, if both FIFOs are non-empty, grant the prioritised source. If only one is non-empty, grant it.
  - After a grant to A the state becomes PRI_B; after a grant to B it becomes PRI_A. With no grant, the state holds.
- Write stage: on a grant edge, the head entry is popped and regWrite=1, writeRegister/writeData = entry. On an edge with no grant, regWrite=0 and writeRegister/writeData hold their values.
- Latency: an entry accepted at edge t drives regWrite no earlier than edge t+1 (visible during cycle t+1..t+2).
- Throughput: 1 write/cycle total. Both sources continuously valid -> A,B,A,B...
- busy_mask is combinational over valid FIFO entries. An entry popped at edge t clears its bit after t, unless another queued entry targets the same register.
- FIFO pointers have ADDR bits of log2(DEPTH)+1 and wrap modulo 2*DEPTH. full = (wr^rd)==DEPTH; empty = wr==rd.

Optional Feature:
WB_FORWARD_EN
- Defined: the readRegister1/2 and fwd_* ports exist.
  - fwd_validN = regWrite && writeRegister==readRegisterN && readRegisterN!=0 (combinational).
  - fwd_dataN = writeData when fwd_validN, else 0.
  - This covers the register file returning stale data in the cycle it is written.
- Undefined: those ports and their logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset with A holding 2 queued entries -> regWrite=0, busy_mask=0, ready_a=ready_b=1; no write appears after reset release.
- A writes r5=0x11 at edge 1 -> regWrite=1, writeRegister=5, writeData=0x11 after edge 2; busy_mask[5]=1 only between edges 1 and 2.
- A and B both valid every cycle (A: r1..r4, B: r8..r11) -> output order r1,r8,r2,r9,r3,r10,r4,r11; one write per cycle.
- B pushes 3 entries with no grants possible (A keeps priority via a stalled test hook or both FIFOs full) -> req_b_ready=0 after DEPTH=2 entries; the third is accepted only after a pop edge.
- A writes r0=0xFF -> accepted (ready high), regWrite never asserted, busy_mask[0]=0.
- WB_FORWARD_EN: regWrite for r7=0xABCD with readRegister1=7, readRegister2=0 -> fwd_valid1=1, fwd_data1=0xABCD, fwd_valid2=0.
